kpn_scheduler: RTL and testbench

- Firing controller for the two-producer / one-adder KPN datapath.
- Issues the queue write strobes and the shared adder read/write strobes.
- Tracks the occupancy of both input FIFOs so that no FIFO overflows or underflows.
- Sits between the divided KPN clock domain logic and the queue, FIFO and adder instances.
- Replaces free-running write and read strobes with a deterministic, bounded schedule.

---
 rtl/kpn_scheduler.sv | 154 +++++++++++++++
 tb/tb_kpn_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kpn_scheduler.sv
// Firing controller for the two-producer / one-adder KPN datapath.
// Generates the producer write strobes and the shared adder read/write strobes
// on tick-enabled cycles while tracking both input FIFO occupancies.
module kpn_scheduler #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned TOKEN_LIMIT = 16,
  parameter int unsigned LIM_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             start,
  input  logic             sink_ready,
  output logic             queue_1_wr,
  output logic             queue_2_wr,
  output logic             adder_rd,
  output logic             adder_wr,
  output logic [CNT_W-1:0] occ_1,
  output logic [CNT_W-1:0] occ_2,
  output logic [LIM_W-1:0] fired,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(FIFO_DEPTH);
  localparam logic [LIM_W-1:0] LIMIT     = LIM_W'(TOKEN_LIMIT);
  localparam bit               UNLIMITED = (TOKEN_LIMIT == 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } main_state_e;

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_READ  = 2'd1,
    A_WAIT  = 2'd2,
    A_WRITE = 2'd3
  } adder_state_e;

  main_state_e      state;
  main_state_e      state_nx;
  adder_state_e     astate;
  adder_state_e     astate_nx;

  logic [LIM_W-1:0] produced_1;
  logic [LIM_W-1:0] produced_2;

  logic             prod_1_open;
  logic             prod_2_open;
  logic             limit_reached;
  logic             fifos_empty;
  logic             fifos_ready;

  // Strobes must coincide with the enabling tick, so they are decoded from state.
  logic             queue_1_wr_c;
  logic             queue_2_wr_c;
  logic             adder_rd_c;
  logic             adder_wr_c;

  assign queue_1_wr = queue_1_wr_c;
  assign queue_2_wr = queue_2_wr_c;
  assign adder_rd   = adder_rd_c;
  assign adder_wr   = adder_wr_c;

  // Firing guards derived from the counters.
  always_comb begin
    prod_1_open   = UNLIMITED || (produced_1 < LIMIT);
    prod_2_open   = UNLIMITED || (produced_2 < LIMIT);
    limit_reached = !UNLIMITED && (produced_1 >= LIMIT) && (produced_2 >= LIMIT);
    fifos_empty   = (occ_1 == '0) && (occ_2 == '0);
    fifos_ready   = (occ_1 != '0) && (occ_2 != '0);
  end

  // State registers for the run FSM and the adder sub-FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      astate <= A_IDLE;
    end else begin
      state  <= state_nx;
      astate <= astate_nx;
    end
  end

  // Next-state logic; nothing advances without a tick.
  always_comb begin
    state_nx  = state;
    astate_nx = astate;
    if (tick) begin
      unique case (state)
        S_IDLE:  if (start)                               state_nx = S_RUN;
        S_RUN:   if (limit_reached)                       state_nx = S_DRAIN;
        S_DRAIN: if (fifos_empty && (astate == A_IDLE))   state_nx = S_DONE;
        S_DONE:  if (!start)                              state_nx = S_IDLE;
        default:                                          state_nx = S_IDLE;
      endcase
      unique case (astate)
        A_IDLE:  if (busy && fifos_ready && sink_ready)   astate_nx = A_READ;
        A_READ:                                           astate_nx = A_WAIT;
        A_WAIT:                                           astate_nx = A_WRITE;
        A_WRITE: if (sink_ready)                          astate_nx = A_IDLE;
        default:                                          astate_nx = A_IDLE;
      endcase
    end
  end

  // Strobe decode: producers only while running, adder by sub-FSM state.
  always_comb begin
    queue_1_wr_c = 1'b0;
    queue_2_wr_c = 1'b0;
    adder_rd_c   = 1'b0;
    adder_wr_c   = 1'b0;
    if (tick) begin
      if (state == S_RUN) begin
        queue_1_wr_c = (occ_1 < DEPTH) && prod_1_open;
        queue_2_wr_c = (occ_2 < DEPTH) && prod_2_open;
      end
      adder_rd_c = (astate == A_READ);
      adder_wr_c = (astate == A_WRITE) && sink_ready;
    end
  end

  // Occupancy, production and firing counters plus the busy/done flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_1      <= '0;
      occ_2      <= '0;
      produced_1 <= '0;
      produced_2 <= '0;
      fired      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (tick) begin
      occ_1 <= occ_1 + CNT_W'(queue_1_wr_c) - CNT_W'(adder_rd_c);
      occ_2 <= occ_2 + CNT_W'(queue_2_wr_c) - CNT_W'(adder_rd_c);
      busy  <= (state_nx == S_RUN) || (state_nx == S_DRAIN);
      done  <= (state_nx == S_DONE);
      if ((state == S_IDLE) && start) begin
        produced_1 <= '0;
        produced_2 <= '0;
        fired      <= '0;
      end else begin
        if (queue_1_wr_c) produced_1 <= produced_1 + LIM_W'(1);
        if (queue_2_wr_c) produced_2 <= produced_2 + LIM_W'(1);
        if (adder_wr_c)   fired      <= fired + LIM_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_kpn_scheduler.sv
// Self-checking bench for kpn_scheduler: four instances with different token
// limits share stimulus; a monitor models FIFO occupancy from the strobes and a
// queue scoreboard predicts the fired count for the instance under test.
module tb_kpn_scheduler;

  localparam int NI = 4;
  localparam int unsigned LIMS [NI] = '{4, 12, 2, 0};

  logic clk;
  logic reset_n;
  logic tick;
  logic start;
  logic sink_ready;

  logic       q1_wr [NI];
  logic       q2_wr [NI];
  logic       rd    [NI];
  logic       wr    [NI];
  logic [3:0] occ1  [NI];
  logic [3:0] occ2  [NI];
  logic [7:0] fired [NI];
  logic       busy  [NI];
  logic       done  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    kpn_scheduler #(
      .FIFO_DEPTH (8),
      .CNT_W      (4),
      .TOKEN_LIMIT(LIMS[g]),
      .LIM_W      (8)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick      (tick),
      .start     (start),
      .sink_ready(sink_ready),
      .queue_1_wr(q1_wr[g]),
      .queue_2_wr(q2_wr[g]),
      .adder_rd  (rd[g]),
      .adder_wr  (wr[g]),
      .occ_1     (occ1[g]),
      .occ_2     (occ2[g]),
      .fired     (fired[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int tick_period = 1;
  int sel = 0;

  int m_occ1 [NI];
  int m_occ2 [NI];
  int n_q1   [NI];
  int n_q2   [NI];
  int n_rd   [NI];
  int n_wr   [NI];

  logic [7:0] exp_q [$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: tick is driven just after the edge, outputs read 3 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    tick = ((cyc % tick_period) == 0);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic run_to_done(input int g, input int budget);
    for (int c = 0; c < budget && !done[g]; c++) step();
    chk($sformatf("done_reached[%0d]", g), done[g], 1);
  endtask

  // Monitor: occupancy model, tick gating, bound check and fired scoreboard.
  initial begin
    logic       chk_pend;
    logic [7:0] chk_val;
    int         tick_n;
    int         last_rd;
    bit         rd_seen;
    chk_pend = 1'b0;
    chk_val  = '0;
    tick_n   = 0;
    last_rd  = 0;
    rd_seen  = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        for (int g = 0; g < NI; g++) begin
          m_occ1[g] = 0; m_occ2[g] = 0;
          n_q1[g] = 0; n_q2[g] = 0; n_rd[g] = 0; n_wr[g] = 0;
        end
        exp_q.delete();
        chk_pend = 1'b0;
        tick_n   = 0;
        rd_seen  = 1'b0;
      end else begin
        if (chk_pend) begin
          chk("fired_scoreboard", fired[sel], chk_val);
          chk_pend = 1'b0;
        end
        for (int g = 0; g < NI; g++) begin
          chk($sformatf("occ_1_model[%0d]", g), occ1[g], m_occ1[g]);
          chk($sformatf("occ_2_model[%0d]", g), occ2[g], m_occ2[g]);
          chk($sformatf("occ_bound[%0d]", g), (occ1[g] <= 8) && (occ2[g] <= 8), 1);
          if (!tick)
            chk($sformatf("strobe_without_tick[%0d]", g), q1_wr[g] | q2_wr[g] | rd[g] | wr[g], 0);
          m_occ1[g] += int'(q1_wr[g]) - int'(rd[g]);
          m_occ2[g] += int'(q2_wr[g]) - int'(rd[g]);
          n_q1[g] += int'(q1_wr[g]);
          n_q2[g] += int'(q2_wr[g]);
          n_rd[g] += int'(rd[g]);
          n_wr[g] += int'(wr[g]);
        end
        if (tick) tick_n++;
        if (rd[sel]) begin
          if (rd_seen) chk("fire_interval_ge4", (tick_n - last_rd) >= 4, 1);
          rd_seen = 1'b1;
          last_rd = tick_n;
          exp_q.push_back(8'(n_rd[sel]));
        end
        if (wr[sel]) begin
          chk("rd_to_wr_ge2", (tick_n - last_rd) >= 2, 1);
          chk("scoreboard_depth", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            chk_val  = exp_q.pop_front();
            chk_pend = 1'b1;
          end
        end
      end
    end
  end

  typedef struct {
    int inst;
    int period;
    int exp_n;
    int budget;
  } vec_t;

  initial begin
    vec_t tbl [4];
    int   v1;
    int   v2;
    int   f0;
    int   prev;
    bit   saw_wrap;
    bit   found;

    tbl[0] = '{0, 1, 4, 200};
    tbl[1] = '{2, 4, 2, 400};
    tbl[2] = '{1, 1, 12, 400};
    tbl[3] = '{1, 3, 12, 1200};

    reset_n = 1'b0;
    tick = 1'b0;
    start = 1'b0;
    sink_ready = 1'b1;
    do_reset();

    // Reset state on every instance.
    for (int g = 0; g < NI; g++)
      chk($sformatf("reset_outputs[%0d]", g),
          {busy[g], done[g], occ1[g], occ2[g], fired[g]}, 0);

    // Table-driven complete runs.
    for (int i = 0; i < 4; i++) begin
      tick_period = tbl[i].period;
      sel = tbl[i].inst;
      sink_ready = 1'b1;
      do_reset();
      start = 1'b1;
      run_to_done(tbl[i].inst, tbl[i].budget);
      chk($sformatf("vec%0d_fired", i), fired[tbl[i].inst], tbl[i].exp_n);
      chk($sformatf("vec%0d_q1_wr", i), n_q1[tbl[i].inst], tbl[i].exp_n);
      chk($sformatf("vec%0d_q2_wr", i), n_q2[tbl[i].inst], tbl[i].exp_n);
      chk($sformatf("vec%0d_adder_rd", i), n_rd[tbl[i].inst], tbl[i].exp_n);
      chk($sformatf("vec%0d_adder_wr", i), n_wr[tbl[i].inst], tbl[i].exp_n);
      chk($sformatf("vec%0d_busy", i), busy[tbl[i].inst], 0);
      chk($sformatf("vec%0d_occ", i), {occ1[tbl[i].inst], occ2[tbl[i].inst]}, 0);
      repeat (3) step();
      chk($sformatf("vec%0d_done_held", i), done[tbl[i].inst], 1);
      start = 1'b0;
      repeat (2 * tbl[i].period) step();
      chk($sformatf("vec%0d_done_cleared", i), done[tbl[i].inst], 0);
    end

    // Reset mid-run, then idle with start low.
    tick_period = 1;
    sel = 1;
    do_reset();
    start = 1'b1;
    repeat (10) step();
    chk("midrun_busy", busy[1], 1);
    reset_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++)
      chk($sformatf("reset_async[%0d]", g),
          {q1_wr[g], q2_wr[g], rd[g], wr[g], busy[g], done[g], occ1[g], occ2[g], fired[g]}, 0);
    start = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("idle_after_reset", {q1_wr[1], q2_wr[1], rd[1], wr[1], busy[1], done[1],
                               occ1[1], occ2[1], fired[1]}, 0);
    end

    // Backpressure: FIFOs saturate at depth, then drain to completion.
    sink_ready = 1'b0;
    do_reset();
    start = 1'b1;
    repeat (30) step();
    chk("bp_occ_1_full", occ1[1], 8);
    chk("bp_occ_2_full", occ2[1], 8);
    chk("bp_q1_writes", n_q1[1], 8);
    chk("bp_q2_writes", n_q2[1], 8);
    chk("bp_no_reads", n_rd[1], 0);
    repeat (10) step();
    chk("bp_still_8_writes", n_q1[1], 8);
    sink_ready = 1'b1;
    run_to_done(1, 400);
    chk("bp_fired", fired[1], 12);
    chk("bp_q1_total", n_q1[1], 12);
    chk("bp_wr_total", n_wr[1], 12);
    start = 1'b0;
    repeat (3) step();

    // Simultaneous write and read leave occupancy unchanged; A_WRITE stall.
    do_reset();
    start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      step();
      found = q1_wr[1] && q2_wr[1] && rd[1];
    end
    chk("simul_found", found, 1);
    v1 = occ1[1];
    v2 = occ2[1];
    step();
    chk("simul_occ_1_same", occ1[1], v1);
    chk("simul_occ_2_same", occ2[1], v2);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      step();
      found = rd[1];
    end
    chk("stall_rd_found", found, 1);
    f0 = fired[1];
    sink_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("stall_wr_low", wr[1], 0);
    end
    chk("stall_fired_held", fired[1], f0);
    sink_ready = 1'b1;
    #1;
    chk("stall_release_wr", wr[1], 1);
    step();
    chk("stall_fired_inc", fired[1], f0 + 1);
    start = 1'b0;
    repeat (3) step();

    // Unlimited mode: 300 firings, fired wraps 255 -> 0, run never ends.
    sel = 3;
    do_reset();
    start = 1'b1;
    prev = 0;
    saw_wrap = 1'b0;
    for (int c = 0; c < 3000 && n_wr[3] < 300; c++) begin
      step();
      if (prev == 255 && fired[3] == 0) saw_wrap = 1'b1;
      prev = fired[3];
    end
    chk("unl_firings", n_wr[3], 300);
    chk("unl_fired_mod256", fired[3], 44);
    chk("unl_wrap_seen", saw_wrap, 1);
    chk("unl_busy", busy[3], 1);
    chk("unl_not_done", done[3], 0);
    chk("unl_still_producing", n_q1[3] >= 300, 1);
    start = 1'b0;
    repeat (5) step();
    chk("unl_busy_after_start_low", busy[3], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
